mdu_ctrl: RTL

//   Multi-cycle multiply/divide unit controller, sits in the E stage beside the ALU.

---
 rtl/mdu_ctrl_pkg.sv | 45 ++++
 rtl/mdu_ctrl_if.sv | 25 ++
 rtl/mdu_ctrl_calc.sv | 110 +++++++++++
 rtl/mdu_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared op encodings, FSM state codes and op-class helpers
// for the multiply/divide unit. Optional feature macro: MDU_MADD_EN
// (enables MADD/MADDU/MSUB/MSUBU as multiply-class ops).
package mdu_ctrl_pkg;

  localparam int MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for the multiply latency.
  function automatic logic isMultClass(input logic [MDU_OP_W-1:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
             (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return r;
  endfunction

  // Ops that occupy the unit for the divide latency.
  function automatic logic isDivClass(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage request/response bundle between the pipeline
// (master) and the multiply/divide unit (slave).
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic                start;
  logic [MDU_OP_W-1:0] MDUop;
  logic [31:0]         A;
  logic [31:0]         B;
  logic                busy;
  logic [31:0]         HI;
  logic [31:0]         LO;
  logic [31:0]         mdu_out;

  modport master (
    output start, MDUop, A, B,
    input  busy, HI, LO, mdu_out
  );

  modport slave (
    input  start, MDUop, A, B,
    output busy, HI, LO, mdu_out
  );

endinterface

// File: rtl/mdu_ctrl_calc.sv
// mdu_calc: purely combinational result generator for the MDU. Given the
// latched op/operands and the current HI/LO it produces the values to commit.
// valid is low for divide-by-zero and for anything that is not an arithmetic op.
// Optional feature macro: MDU_MADD_EN (accumulating multiply variants).
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [31:0]         a_i,
  input  logic [31:0]         b_i,
  input  logic [31:0]         hi_i,
  input  logic [31:0]         lo_i,
  output logic [31:0]         hi_o,
  output logic [31:0]         lo_o,
  output logic                valid_o
);

  logic [63:0] sProd;
  logic [63:0] uProd;
  logic [63:0] acc;
  logic        aNeg;
  logic        bNeg;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] uDivisor;
  logic [31:0] sDivisor;
  logic [31:0] uQuot;
  logic [31:0] uRem;
  logic [31:0] sQuotMag;
  logic [31:0] sRemMag;
  logic [31:0] sQuot;
  logic [31:0] sRem;
  logic        divByZero;

  // Sign-extending both operands to 64 bits makes the low 64 bits of the
  // product the exact two's-complement result.
  assign sProd = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign uProd = {32'd0, a_i} * {32'd0, b_i};
  assign acc   = {hi_i, lo_i};

  // Signed divide is done on magnitudes and the signs are fixed afterwards;
  // this gives truncation toward zero, a remainder carrying the dividend's
  // sign, and 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  // A zero divisor is swapped for 1 so the dividers never see it; the
  // result is discarded through valid_o anyway.
  assign divByZero = (b_i == 32'd0);
  assign aNeg      = a_i[31];
  assign bNeg      = b_i[31];
  assign absA      = aNeg ? (32'd0 - a_i) : a_i;
  assign absB      = bNeg ? (32'd0 - b_i) : b_i;
  assign uDivisor  = divByZero ? 32'd1 : b_i;
  assign sDivisor  = divByZero ? 32'd1 : absB;
  assign uQuot     = a_i / uDivisor;
  assign uRem      = a_i % uDivisor;
  assign sQuotMag  = absA / sDivisor;
  assign sRemMag   = absA % sDivisor;
  assign sQuot     = (aNeg ^ bNeg) ? (32'd0 - sQuotMag) : sQuotMag;
  assign sRem      = aNeg ? (32'd0 - sRemMag) : sRemMag;

  // Select the commit value for the latched op; default leaves HI/LO alone.
  always_comb begin
    hi_o    = hi_i;
    lo_o    = lo_i;
    valid_o = 1'b0;
    case (op_i)
      MDU_MULT: begin
        {hi_o, lo_o} = sProd;
        valid_o      = 1'b1;
      end
      MDU_MULTU: begin
        {hi_o, lo_o} = uProd;
        valid_o      = 1'b1;
      end
      MDU_DIV: begin
        hi_o    = sRem;
        lo_o    = sQuot;
        valid_o = !divByZero;
      end
      MDU_DIVU: begin
        hi_o    = uRem;
        lo_o    = uQuot;
        valid_o = !divByZero;
      end
`ifdef MDU_MADD_EN
      MDU_MADD: begin
        {hi_o, lo_o} = acc + sProd;
        valid_o      = 1'b1;
      end
      MDU_MADDU: begin
        {hi_o, lo_o} = acc + uProd;
        valid_o      = 1'b1;
      end
      MDU_MSUB: begin
        {hi_o, lo_o} = acc - sProd;
        valid_o      = 1'b1;
      end
      MDU_MSUBU: begin
        {hi_o, lo_o} = acc - uProd;
        valid_o      = 1'b1;
      end
`endif
      default: begin
        hi_o    = hi_i;
        lo_o    = lo_i;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller in the E stage. Latches
// one MULT/DIV-class op per start pulse, stays busy for a fixed latency and
// then commits the 64-bit result to HI/LO. Also serves MTHI/MTLO/MFHI/MFLO.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU, multiply latency).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)(
  input  logic      clk,
  input  logic      reset,
  mdu_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;

  logic        inBusy;
  logic        latchEn;
  logic        commitEn;
  logic        mtHiEn;
  logic        mtLoEn;
  logic        lastCycle;
  logic [31:0] calcHi;
  logic [31:0] calcLo;
  logic        calcValid;

  assign lastCycle = (cnt_q == CNT_W'(1));

  mdu_calc u_calc (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .hi_o    (calcHi),
    .lo_o    (calcLo),
    .valid_o (calcValid)
  );

  // FSM state and latency counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: start only matters in IDLE; BUSY counts down to the commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MDU_IDLE: begin
        if (bus.start && isMultClass(bus.MDUop)) begin
          state_d = MDU_BUSY;
          cnt_d   = CNT_W'(MULT_CYCLES);
        end else if (bus.start && isDivClass(bus.MDUop)) begin
          state_d = MDU_BUSY;
          cnt_d   = CNT_W'(DIV_CYCLES);
        end
      end
      MDU_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: busy flag and the enables that steer the datapath registers.
  always_comb begin
    inBusy   = (state_q == MDU_BUSY);
    latchEn  = 1'b0;
    commitEn = 1'b0;
    mtHiEn   = 1'b0;
    mtLoEn   = 1'b0;
    if (state_q == MDU_IDLE) begin
      latchEn = bus.start && (isMultClass(bus.MDUop) || isDivClass(bus.MDUop));
      mtHiEn  = (bus.MDUop == MDU_MTHI);
      mtLoEn  = (bus.MDUop == MDU_MTLO);
    end else begin
      commitEn = lastCycle && calcValid;
    end
  end

  // Datapath next values: operand latch on issue, HI/LO from commit or MTxx.
  always_comb begin
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (latchEn) begin
      op_d = bus.MDUop;
      a_d  = bus.A;
      b_d  = bus.B;
    end
    if (commitEn) begin
      hi_d = calcHi;
      lo_d = calcLo;
    end
    if (mtHiEn) begin
      hi_d = bus.A;
    end
    if (mtLoEn) begin
      lo_d = bus.A;
    end
  end

  // Datapath registers; reset discards any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // MFHI/MFLO read port; during BUSY this still shows the pre-op HI/LO.
  always_comb begin
    bus.mdu_out = 32'd0;
    if (bus.MDUop == MDU_MFHI) begin
      bus.mdu_out = hi_q;
    end else if (bus.MDUop == MDU_MFLO) begin
      bus.mdu_out = lo_q;
    end
  end

  assign bus.busy = inBusy;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
